camera_capture_packer: RTL
==========================

// Module: camera_capture_packer
// PURPOSE
// - Upstream stage of the camera_1 input PIO: samples an 8-bit parallel camera bus (OV7670 style) in the clk domain.
// - Packs byte pairs into RGB565 pixels and tags them with frame and line markers.
// - Buffers pixels in a FIFO and presents one 26-bit status/pixel word with a valid/ready pop handshake.
// PARAMETERS
// - FIFO_AW   4    FIFO address width; depth = 2**FIFO_AW entries of 18 bits {eol,sof,pixel}
// - LINE_W    640  pixels per line; x counter wraps here and eol is tagged at x==LINE_W-1
// PORTS
// - clk         in   1   system clock; all logic on rising edge; must be >= 4x cam_pclk
// - reset       in   1   synchronous, active-high reset
// - cam_pclk    in   1   camera pixel clock, asynchronous; sampled as data, never used as a clock
// - cam_vsync   in   1   camera vsync, async; high = vertical blanking
// - cam_href    in   1   camera href, async; high = active bytes
// - cam_data    in   8   camera data byte, async
// - capture_en  in   1   capture enable
// - ovf_clr     in   1   one-cycle pulse; clears the sticky overflow flag
// - out_ready   in   1   consumer pops the head word when out_ready && out_valid
// - out_valid   out  1   FIFO not empty
// - out_word    out  26  [15:0] pixel; [16] sof; [17] eol; [18] overflow; [19] out_valid; [25:20] frame_cnt
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM in IDLE, x=y=0, frame_cnt=0, byte phase=HI, overflow=0.
// - Sync: pclk/vsync/href/data each pass through 2 flops. A pclk rise is sync_pclk & ~prev, giving 1-cycle pclk_rise.
// - FSM states:
//   - IDLE: wait for capture_en=1 and synced vsync=1 -> VBLANK.
//   - VBLANK: on synced vsync falling edge -> ACTIVE; frame_cnt++ (6-bit wrap); y=0; arm sof.
//   - ACTIVE: on pclk_rise with href=1, capture a byte.
//     - Phase HI: store the byte.
//     - Phase LO: pixel={hi,lo}, push to FIFO, x++.
//   - ACTIVE exits:
//     - vsync rise -> VBLANK.
//     - capture_en=0 -> IDLE immediately; any held HI byte is discarded; FIFO contents are kept.
// - Tags: sof=1 on the first pixel pushed after entering ACTIVE only. eol=1 when x==LINE_W-1, then x wraps to 0.
// - Href fall: byte phase resets to HI (a dangling odd byte is dropped); y++; x=0.
//   - If x!=0 at href fall (short line), no eol is emitted for that line.
// - Latency: out_valid asserts exactly 5 clk cycles after the cam_pclk rise of the LO byte, FIFO previously empty.
//   - 2 cycles sync, 1 cycle edge detect, 1 cycle push, 1 cycle FIFO output register.
// - FIFO:
//   - Push when full: pixel dropped, overflow set; overflow stays 1 until ovf_clr or reset. ovf_clr and a new overflow in the same cycle: overflow=1.
//   - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
//   - Pop when empty: ignored.
//   - out_word[15:0], [16] and [17] show the head entry. These bits are 0 when the FIFO is empty.
//   - Pointers wrap modulo 2**FIFO_AW; count is FIFO_AW+1 bits wide.
// - out_word[18], [19] and [25:20] are live status bits and do not depend on FIFO contents.
// - Reset mid-frame: FSM returns to IDLE, FIFO flushed; the next frame starts only after a full vsync high->low.
// CONFIGURATION
// - CAPTURE_TEST_PATTERN_EN defined:
//   - When cam_data is used in phase LO, the captured pixel is replaced by {y[4:0], x[5:0], frame_cnt[4:0]}.
//   - Timing, tags and handshake are unchanged; the camera still supplies pclk, href and vsync.
// - CAPTURE_TEST_PATTERN_EN undefined: pixel = {hi_byte, lo_byte}; no pattern logic is synthesised.
// TESTING
// - Reset then idle 20 cycles -> out_word==26'h0, out_valid=0.
// - LINE_W=4; 1 frame, 2 lines of 8 bytes 0x01..0x08; pop every cycle -> pixels 0x0102,0x0304,0x0506,0x0708 per line.
//   - sof on the first pixel only; eol on the 4th pixel of each line; frame_cnt=1.
// - FIFO_AW=2, out_ready=0; push 5 pixels -> 4 stored, overflow=1. ovf_clr pulse -> overflow=0; FIFO still holds 4.
// - FIFO full, out_ready=1, push coincides with pop -> no overflow; count stays 4; order preserved.
// - Drop capture_en after the HI byte of a pixel -> IDLE; no pixel pushed; re-enable -> capture resumes only after the next vsync fall.
// - LO-byte pclk rise into an empty FIFO -> out_valid rises exactly 5 clk cycles later.
//   - With CAPTURE_TEST_PATTERN_EN: first pixel of frame 1 = 16'h0001.

Source files
------------

// File: rtl/camera_capture_packer.sv
// -----------------------------------------------------------------------------
// camera_capture_packer
//
// Purpose:
//   Upstream stage of the camera_1 input path. Samples an 8-bit parallel camera
//   bus (OV7670 style) in the clk domain, packs HI/LO byte pairs into RGB565
//   pixels, tags them with start-of-frame / end-of-line markers, buffers them in
//   a small FIFO and presents a 26-bit status/pixel word with a valid/ready pop.
//
// Configuration macro:
//   CAPTURE_TEST_PATTERN_EN - when defined, each packed pixel is replaced by
//   {y[4:0], x[5:0], frame_cnt[4:0]}; timing, tags and handshake are unchanged.
//   When undefined, pixel = {hi_byte, lo_byte} and no pattern logic exists.
//
// Parameters:
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW entries of {eol,sof,pixel}
//   LINE_W   pixels per line; x wraps here, eol tagged at x == LINE_W-1
//
// Ports:
//   clk         in   system clock (>= 4x cam_pclk), all logic on rising edge
//   reset       in   synchronous active-high reset
//   cam_pclk    in   camera pixel clock, sampled as data only
//   cam_vsync   in   camera vsync, high = vertical blanking
//   cam_href    in   camera href, high = active bytes
//   cam_data    in   camera data byte
//   capture_en  in   capture enable
//   ovf_clr     in   one-cycle pulse, clears sticky overflow flag
//   out_ready   in   consumer pops head word when out_ready && out_valid
//   out_valid   out  FIFO not empty
//   out_word    out  [15:0] pixel, [16] sof, [17] eol, [18] overflow,
//                    [19] out_valid, [25:20] frame_cnt
// -----------------------------------------------------------------------------
module camera_capture_packer #(
  parameter int FIFO_AW = 4,
  parameter int LINE_W  = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  input  logic        ovf_clr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [25:0] out_word
);

  localparam int XW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int YW    = 10;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic       pclk_m_r, pclk_s_r, pclk_prev_r, pclk_rise_r;
  logic       vsync_m_r, vsync_s_r, vsync_d_r, vsync_prev_r;
  logic       href_m_r, href_s_r, href_d_r, href_prev_r;
  logic [7:0] data_m_r, data_s_r, data_d_r;

  // Two-flop synchronisers followed by one aligned stage, so the registered
  // pclk rise strobe lines up with the href/vsync/data values it qualifies.
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_m_r     <= 1'b0;
      pclk_s_r     <= 1'b0;
      pclk_prev_r  <= 1'b0;
      pclk_rise_r  <= 1'b0;
      vsync_m_r    <= 1'b0;
      vsync_s_r    <= 1'b0;
      vsync_d_r    <= 1'b0;
      vsync_prev_r <= 1'b0;
      href_m_r     <= 1'b0;
      href_s_r     <= 1'b0;
      href_d_r     <= 1'b0;
      href_prev_r  <= 1'b0;
      data_m_r     <= 8'h00;
      data_s_r     <= 8'h00;
      data_d_r     <= 8'h00;
    end else begin
      pclk_m_r     <= cam_pclk;
      pclk_s_r     <= pclk_m_r;
      pclk_prev_r  <= pclk_s_r;
      pclk_rise_r  <= pclk_s_r & ~pclk_prev_r;
      vsync_m_r    <= cam_vsync;
      vsync_s_r    <= vsync_m_r;
      vsync_d_r    <= vsync_s_r;
      vsync_prev_r <= vsync_d_r;
      href_m_r     <= cam_href;
      href_s_r     <= href_m_r;
      href_d_r     <= href_s_r;
      href_prev_r  <= href_d_r;
      data_m_r     <= cam_data;
      data_s_r     <= data_m_r;
      data_d_r     <= data_s_r;
    end
  end

  logic vsync_fall_s, vsync_rise_s, href_fall_s;
  assign vsync_fall_s = vsync_prev_r & ~vsync_d_r;
  assign vsync_rise_s = ~vsync_prev_r & vsync_d_r;
  assign href_fall_s  = href_prev_r & ~href_d_r;

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_t          state_r, state_next;
  logic            start_frame_s, line_end_s, byte_hi_s, byte_lo_s;
  logic            phase_lo_r;
  logic            sof_arm_r;
  logic [7:0]      hi_r;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic [5:0]      frame_cnt_r;
  logic [15:0]     pixel_s;
  logic            eol_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic and per-cycle capture strobes.
  always_comb begin
    state_next    = state_r;
    start_frame_s = 1'b0;
    line_end_s    = 1'b0;
    byte_hi_s     = 1'b0;
    byte_lo_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture_en && vsync_d_r) begin
          state_next = VBLANK;
        end else begin
          state_next = IDLE;
        end
      end
      VBLANK: begin
        if (!capture_en) begin
          state_next = IDLE;
        end else if (vsync_fall_s) begin
          state_next    = ACTIVE;
          start_frame_s = 1'b1;
        end else begin
          state_next = VBLANK;
        end
      end
      ACTIVE: begin
        if (!capture_en) begin
          state_next = IDLE;
        end else if (vsync_rise_s) begin
          state_next = VBLANK;
        end else if (href_fall_s) begin
          line_end_s = 1'b1;
        end else if (pclk_rise_r && href_d_r) begin
          byte_hi_s = ~phase_lo_r;
          byte_lo_s = phase_lo_r;
        end else begin
          state_next = ACTIVE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pixel content selection and eol tag for the pixel completed this cycle.
`ifdef CAPTURE_TEST_PATTERN_EN
  logic [15:0] x_ext_s, y_ext_s;
  always_comb begin
    x_ext_s = 16'(x_r);
    y_ext_s = 16'(y_r);
    pixel_s = {y_ext_s[4:0], x_ext_s[5:0], frame_cnt_r[4:0]};
    eol_s   = (x_r == XW'(LINE_W - 1));
  end
`else
  always_comb begin
    pixel_s = {hi_r, data_d_r};
    eol_s   = (x_r == XW'(LINE_W - 1));
  end
`endif

  logic        push_r;
  logic [17:0] push_entry_r;

  // Frame/line counters, byte phase and the registered push request.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_lo_r   <= 1'b0;
      sof_arm_r    <= 1'b0;
      hi_r         <= 8'h00;
      x_r          <= '0;
      y_r          <= '0;
      frame_cnt_r  <= 6'd0;
      push_r       <= 1'b0;
      push_entry_r <= 18'h0;
    end else begin
      push_r <= 1'b0;
      if (start_frame_s) begin
        frame_cnt_r <= frame_cnt_r + 6'd1;
        y_r         <= '0;
        x_r         <= '0;
        phase_lo_r  <= 1'b0;
        sof_arm_r   <= 1'b1;
      end else if (line_end_s) begin
        // A dangling odd byte is dropped; short lines get no eol.
        phase_lo_r <= 1'b0;
        y_r        <= y_r + YW'(1);
        x_r        <= '0;
      end else if (byte_hi_s) begin
        hi_r       <= data_d_r;
        phase_lo_r <= 1'b1;
      end else if (byte_lo_s) begin
        push_r       <= 1'b1;
        push_entry_r <= {eol_s, sof_arm_r, pixel_s};
        sof_arm_r    <= 1'b0;
        phase_lo_r   <= 1'b0;
        x_r          <= eol_s ? '0 : (x_r + XW'(1));
      end else if (state_r != ACTIVE) begin
        // Leaving ACTIVE discards any held HI byte.
        phase_lo_r <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO with registered head/status outputs
  // ---------------------------------------------------------------------------
  logic [17:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r, rd_next_s, wr_next_s;
  logic [CW-1:0]      count_r, count_next_s;
  logic               full_s, pop_s, push_acc_s, ovf_event_s;
  logic [17:0]        head_r, head_next_s;
  logic               overflow_r, overflow_next_s;
  logic               out_valid_r;

  // Push/pop arbitration and next head value; the head register is loaded
  // from next-state so it always matches the FIFO contents.
  always_comb begin
    full_s      = (count_r == CW'(DEPTH));
    pop_s       = out_ready && (count_r != CW'(0));
    push_acc_s  = push_r && (!full_s || pop_s);
    ovf_event_s = push_r && full_s && !pop_s;
    rd_next_s   = pop_s ? (rd_ptr_r + FIFO_AW'(1)) : rd_ptr_r;
    wr_next_s   = push_acc_s ? (wr_ptr_r + FIFO_AW'(1)) : wr_ptr_r;
    case ({push_acc_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    if (count_next_s == CW'(0)) begin
      head_next_s = 18'h0;
    end else if (push_acc_s && (wr_ptr_r == rd_next_s)) begin
      // Next head is the entry being written this cycle.
      head_next_s = push_entry_r;
    end else begin
      head_next_s = mem[rd_next_s];
    end
    if (ovf_event_s) begin
      overflow_next_s = 1'b1;
    end else if (ovf_clr) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem[wr_ptr_r] <= push_entry_r;
    end
  end

  // FIFO pointers, count, head and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      head_r      <= 18'h0;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_next_s;
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      head_r      <= head_next_s;
      overflow_r  <= overflow_next_s;
      out_valid_r <= (count_next_s != CW'(0));
    end
  end

  assign out_valid = out_valid_r;
  assign out_word  = {frame_cnt_r, out_valid_r, overflow_r, head_r};

endmodule
